// File: rtl/wb_dcache.sv
// Write-back, write-allocate, direct-mapped data cache. The core stalls on `miss`.
// Refills and evictions run as word bursts to a single-word memory port.
module wb_dcache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [3:0]  wr_be,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int LINES = 1 << SET_ADDR_LEN;
    localparam int DEPTH = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);
    localparam logic [LINE_ADDR_LEN-1:0] WORD0 = '0;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t                  state;
    logic [TAG_ADDR_LEN-1:0] tags [LINES];
    logic [31:0]             data [DEPTH];
    logic [LINES-1:0]        valid;
    logic [LINES-1:0]        dirty;

    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [LINE_ADDR_LEN-1:0] cnt_next;

    logic [TAG_ADDR_LEN-1:0]  tag_i;
    logic [SET_ADDR_LEN-1:0]  set_i;
    logic [LINE_ADDR_LEN-1:0] word_i;
    logic                     active;
    logic                     hit;
    logic                     last_beat;
    logic                     unused_addr;

    assign tag_i       = addr[31 -: TAG_ADDR_LEN];
    assign set_i       = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
    assign word_i      = addr[LINE_ADDR_LEN+1:2];
    assign unused_addr = ^addr[1:0];

    assign active    = rd_req | wr_req;
    assign hit       = valid[set_i] && (tags[set_i] == tag_i) && (state == IDLE);
    assign miss      = active && !hit;
    assign cnt_next  = cnt + 1'b1;
    assign last_beat = (cnt == '1);

    // Control, valid/dirty and the registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            rd_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active && hit) begin
                        if (rd_req) rd_data <= data[{set_i, word_i}];
                        if (wr_req) dirty[set_i] <= 1'b1;
                    end else if (active) begin
                        req_tag <= tag_i;
                        req_set <= set_i;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (valid[set_i] && dirty[set_i]) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tags[set_i], set_i, WORD0, 2'b00};
                            mem_wdata <= data[{set_i, WORD0}];
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag_i, set_i, WORD0, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        if (last_beat) begin
                            cnt     <= '0;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            state   <= FILL;
                        end else begin
                            cnt       <= cnt_next;
                            mem_addr  <= {tags[req_set], req_set, cnt_next, 2'b00};
                            mem_wdata <= data[{req_set, cnt_next}];
                        end
                    end
                end
                FILL: begin
                    // Entered from WB with the port idle for one cycle; start the read burst here.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {req_tag, req_set, WORD0, 2'b00};
                    end else if (mem_ack) begin
                        if (last_beat) begin
                            cnt            <= '0;
                            mem_req        <= 1'b0;
                            valid[req_set] <= 1'b1;
                            dirty[req_set] <= 1'b0;
                            state          <= DONE;
                        end else begin
                            cnt      <= cnt_next;
                            mem_addr <= {req_tag, req_set, cnt_next, 2'b00};
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (active && hit && wr_req) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (wr_be[b]) data[{set_i, word_i}][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end else if (state == FILL && mem_req && mem_ack) begin
                data[{req_set, cnt}] <= mem_rdata;
                if (last_beat) tags[req_set] <= req_tag;
            end
        end
    end
endmodule

// File: doc/wb_dcache.md
Name: wb_dcache

Overview:
- Write-back, write-allocate, direct-mapped data cache.
- Sits between the EX/MEM boundary (address, store data and byte enables from the execute stage) and a word-wide main-memory model.
- Instantiated inside the MEM-WB segment register. Its `miss` output drives the hazard unit's DCacheMiss input, which stalls the pipeline until the access hits.

Parameters:
- LINE_ADDR_LEN, 3: log2 words per line (8 words).
- SET_ADDR_LEN, 4: log2 number of lines (16 lines).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (derived; do not override).

Ports:
- clk  in  1  CPU clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- rd_req  in  1  load request (MemToRegE).
- wr_req  in  1  store request (|MemWriteE).
- wr_be  in  4  store byte enables.
- addr  in  32  byte address; bits [1:0] are ignored for indexing.
- wr_data  in  32  store data, already lane-aligned.
- rd_data  out  32  load word, registered.
- miss  out  1  combinational; the request is not yet served, so the core must stall and hold its inputs.
- mem_req  out  1  memory word transfer request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write-beat data.
- mem_ack  in  1  beat complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read-beat data.

Behaviour:
- Address split: tag = addr[31 -: TAG_ADDR_LEN]; set = next SET_ADDR_LEN bits; word = addr[LINE_ADDR_LEN+1:2].
- Storage: per-line valid bit, dirty bit, tag, and LINE_WORDS x 32 data.
- Reset (synchronous): all valid and dirty bits cleared; state=IDLE; rd_data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; beat counter=0. Data and tag arrays are not cleared.
- A request is active when rd_req or wr_req is high. If both are high, the write is performed and rd_data also returns the pre-write word.
- hit = valid[set] && tag match && state==IDLE.
- miss = active && !hit. It is 0 when there is no request.
- Read hit: rd_data <= line word at the next edge (1-cycle latency, data valid in the cycle after the hit).
- Write hit: the enabled bytes are written at the edge; dirty[set] <= 1. Bytes not enabled are unchanged.
- FSM states: IDLE, WB, FILL, DONE.
  - IDLE -> WB on active && !hit && valid && dirty.
  - IDLE -> FILL on active && !hit && !(valid && dirty).
  - WB: issue LINE_WORDS write beats to {old_tag, set, cnt, 2'b00}. mem_req and mem_we are held high until mem_ack. On each ack cnt++. After the last ack, cnt wraps to 0 and the FSM goes to FILL.
  - FILL: issue read beats to {req_tag, set, cnt, 2'b00}. Each mem_rdata is written to word cnt on ack. After the last ack: tag<=req_tag, valid<=1, dirty<=0, FSM -> DONE.
  - DONE: one bubble cycle (miss still 1), then -> IDLE. The held request now hits and is served as a normal hit.
- mem_req drops the cycle after the final ack of a burst. Between the WB and FILL bursts there is exactly one cycle with mem_req=0.
- The tag and set for the miss are latched on leaving IDLE. If core inputs change during the miss (protocol violation), the fill still completes for the latched line.
- Requests with addr[1:0]!=0 use the word index only; byte alignment is the store/load-extend logic's job.
- Reset during WB or FILL: the burst is aborted immediately, mem_req=0 at the next edge, all lines are invalidated, and the partially written line is discarded.
- No request (rd_req=wr_req=0): no state change, rd_data holds its value.
- Miss penalty with a 0-wait memory (ack in the cycle after req is seen):
  - Clean miss: LINE_WORDS + 2 cycles of miss.
  - Dirty miss: 2*LINE_WORDS + 3 cycles of miss.

Test Plan:
- After reset, rd_req addr=0x100 -> miss=1, FSM FILL, 8 read beats to 0x100..0x11C. With memory returning word = address: DONE bubble, then miss=0 and rd_data=0x100 the next cycle. Total miss cycles = 10.
- Write hit: wr_req addr=0x104, be=4'b0011, data=0xAABBCCDD after the fill above -> miss=0. Then read 0x104 -> rd_data=0x0000CCDD (old word 0x104 upper bytes 0x0000).
- Conflict eviction: after the previous test, read 0x904 (same set, different tag) -> WB beats write 0x100..0x11C, including 0x0000CCDD at 0x104, then FILL reads 0x900..0x91C. Final rd_data=0x904.
- Clean eviction: read 0x100, read 0x900 with no writes in between -> no write beats (mem_we never 1); only 8 read beats.
- Reset mid-FILL: assert rst after the 3rd read ack -> next cycle mem_req=0, state IDLE. Re-reading the same address produces a full 8-beat refill.
- Memory wait states: mem_ack delayed 3 cycles per beat -> mem_req/mem_we/mem_addr are held stable while waiting, and the final data is still correct.
